// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder
//   Recovers a magnitude estimate from a neuron spike train. Spikes are counted
//   over a window of WINDOW enabled cycles. The interval between the last two
//   spikes (ISI) is measured in enabled cycles. At each window end both values
//   are offered to the downstream readout through a valid/ready result register.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   spike_in   spike from the neuron, sampled every cycle
//   enable     low freezes window progress, spike counting and ISI counting
//   rate_out   spike count of the last completed window (saturating)
//   isi_out    last complete ISI, latched at window end (saturating)
//   out_valid  result register holds an unconsumed result
//   out_ready  consumer accepts the result when high together with out_valid
//   overrun    sticky: a window result was dropped because the consumer stalled
//
// State table
//   state   | meaning
//   S_IDLE  | enable low (or just out of reset); all counters hold
//   S_COUNT | enable high; window, spike and ISI counters advance
//
// Counting is keyed directly on enable rather than on the registered state.
// This lets the first enabled cycle after S_IDLE count as a window cycle.
// Re-entering S_COUNT therefore resumes the window instead of restarting it.

module spike_rate_decoder #(
    parameter int WINDOW = 16,
    parameter int CNT_W  = 8,
    parameter int ISI_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spike_in,
    input  logic             enable,
    output logic [CNT_W-1:0] rate_out,
    output logic [ISI_W-1:0] isi_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun
);

    localparam int                WCNT_W   = $clog2(WINDOW);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(WINDOW - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [WCNT_W-1:0]  wcnt, wcnt_nxt;
    logic [CNT_W-1:0]   spike_cnt, spike_cnt_nxt, spike_cnt_upd;
    logic [ISI_W-1:0]   isi_cnt, isi_cnt_nxt;
    logic [ISI_W-1:0]   isi_reg, isi_reg_nxt;
    logic               seen_spike, seen_spike_nxt;
    logic [CNT_W-1:0]   rate_nxt;
    logic [ISI_W-1:0]   isi_out_nxt;
    logic               out_valid_nxt;
    logic               overrun_nxt;
    logic               win_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            wcnt       <= '0;
            spike_cnt  <= '0;
            isi_cnt    <= '0;
            isi_reg    <= '0;
            seen_spike <= 1'b0;
            rate_out   <= '0;
            isi_out    <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            wcnt       <= wcnt_nxt;
            spike_cnt  <= spike_cnt_nxt;
            isi_cnt    <= isi_cnt_nxt;
            isi_reg    <= isi_reg_nxt;
            seen_spike <= seen_spike_nxt;
            rate_out   <= rate_nxt;
            isi_out    <= isi_out_nxt;
            out_valid  <= out_valid_nxt;
            overrun    <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        wcnt_nxt       = wcnt;
        spike_cnt_upd  = spike_cnt;
        spike_cnt_nxt  = spike_cnt;
        isi_cnt_nxt    = isi_cnt;
        isi_reg_nxt    = isi_reg;
        seen_spike_nxt = seen_spike;
        rate_nxt       = rate_out;
        isi_out_nxt    = isi_out;
        out_valid_nxt  = out_valid;
        overrun_nxt    = overrun;
        win_end        = 1'b0;

        case (state)
            S_IDLE:  if (enable)  state_nxt = S_COUNT;
            S_COUNT: if (!enable) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        if (enable) begin
            win_end  = (wcnt == WCNT_MAX);
            wcnt_nxt = win_end ? '0 : wcnt + 1'b1;

            if (spike_in && (spike_cnt != '1))
                spike_cnt_upd = spike_cnt + 1'b1;
            spike_cnt_nxt = spike_cnt_upd;

            if (spike_in) begin
                // The first spike after reset only arms the interval measurement.
                if (seen_spike)
                    isi_reg_nxt = (isi_cnt == '1) ? isi_cnt : isi_cnt + 1'b1;
                seen_spike_nxt = 1'b1;
                isi_cnt_nxt    = '0;
            end else if (isi_cnt != '1) begin
                isi_cnt_nxt = isi_cnt + 1'b1;
            end
        end

        if (win_end) begin
            spike_cnt_nxt = '0;
            if (!out_valid || out_ready) begin
                rate_nxt      = spike_cnt_upd;
                isi_out_nxt   = isi_reg_nxt;
                out_valid_nxt = 1'b1;
            end else begin
                overrun_nxt = 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Testbench for spike_rate_decoder. The same stimulus drives two instances.
// Instance A uses the default widths. Instance B uses narrow widths so that
// count and ISI saturation are reached easily. The reference model tracks the
// spike positions in units of enabled cycles since reset. The window count is
// the number of spikes in the current window. The ISI is the distance between
// the last two spikes. Both values are clipped to each instance's maximum.

module tb_spike_rate_decoder;

    localparam int WINDOW = 16;
    localparam int A_CNT_MAX = 255;
    localparam int A_ISI_MAX = 255;
    localparam int B_CNT_MAX = 7;
    localparam int B_ISI_MAX = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       spike_in;
    logic       enable;
    logic       out_ready;

    logic [7:0] rate_a;
    logic [7:0] isi_a;
    logic       val_a;
    logic       ovr_a;
    logic [2:0] rate_b;
    logic [3:0] isi_b;
    logic       val_b;
    logic       ovr_b;

    always #5 clk = ~clk;

    spike_rate_decoder #(.WINDOW(WINDOW), .CNT_W(8), .ISI_W(8)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .spike_in  (spike_in),
        .enable    (enable),
        .rate_out  (rate_a),
        .isi_out   (isi_a),
        .out_valid (val_a),
        .out_ready (out_ready),
        .overrun   (ovr_a)
    );

    spike_rate_decoder #(.WINDOW(WINDOW), .CNT_W(3), .ISI_W(4)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .spike_in  (spike_in),
        .enable    (enable),
        .rate_out  (rate_b),
        .isi_out   (isi_b),
        .out_valid (val_b),
        .out_ready (out_ready),
        .overrun   (ovr_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int en_idx;
    int win_spikes;
    int last_spike_idx;
    bit have_spike;
    int isi_raw;
    bit exp_valid;
    bit exp_ovr;
    int exp_rate_a, exp_isi_a, exp_rate_b, exp_isi_b;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_edge(input logic r, input logic en, input logic sp, input logic rdy);
        bit win_end;
        if (r) begin
            en_idx = 0; win_spikes = 0; last_spike_idx = 0; have_spike = 0;
            isi_raw = 0; exp_valid = 0; exp_ovr = 0;
            exp_rate_a = 0; exp_isi_a = 0; exp_rate_b = 0; exp_isi_b = 0;
            return;
        end
        win_end = 0;
        if (en) begin
            if (sp) begin
                if (have_spike)
                    isi_raw = en_idx - last_spike_idx;
                last_spike_idx = en_idx;
                have_spike     = 1;
                win_spikes++;
            end
            win_end = ((en_idx % WINDOW) == WINDOW - 1);
            en_idx++;
        end
        if (win_end) begin
            if (!exp_valid || rdy) begin
                exp_rate_a = min_i(win_spikes, A_CNT_MAX);
                exp_rate_b = min_i(win_spikes, B_CNT_MAX);
                exp_isi_a  = min_i(isi_raw, A_ISI_MAX);
                exp_isi_b  = min_i(isi_raw, B_ISI_MAX);
                exp_valid  = 1;
            end else begin
                exp_ovr = 1;
            end
            win_spikes = 0;
        end else if (exp_valid && rdy) begin
            exp_valid = 0;
        end
    endtask

    task automatic compare_all(input string phase);
        check({phase, ":rate_a"}, int'(rate_a), exp_rate_a);
        check({phase, ":isi_a"},  int'(isi_a),  exp_isi_a);
        check({phase, ":val_a"},  int'(val_a),  int'(exp_valid));
        check({phase, ":ovr_a"},  int'(ovr_a),  int'(exp_ovr));
        check({phase, ":rate_b"}, int'(rate_b), exp_rate_b);
        check({phase, ":isi_b"},  int'(isi_b),  exp_isi_b);
        check({phase, ":val_b"},  int'(val_b),  int'(exp_valid));
        check({phase, ":ovr_b"},  int'(ovr_b),  int'(exp_ovr));
    endtask

    task automatic cycle(input string phase, input logic r, input logic en,
                         input logic sp, input logic rdy);
        rst = r; enable = en; spike_in = sp; out_ready = rdy;
        @(posedge clk);
        model_edge(r, en, sp, rdy);
        #1;
        compare_all(phase);
    endtask

    task automatic do_reset();
        cycle("reset", 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("reset", 1'b1, 1'b1, 1'b1, 1'b1);
    endtask

    int p_sp, p_en, p_rdy;

    initial begin
        rst = 1'b1; enable = 1'b0; spike_in = 1'b0; out_ready = 1'b0;
        do_reset();
        check("rst_rate_a", int'(rate_a), 0);
        check("rst_valid_a", int'(val_a), 0);

        // spikes every 4th enabled cycle, consumer always ready
        for (int i = 0; i < 24; i++)
            cycle("t1", 1'b0, 1'b1, (i % 4) == 0, 1'b1);

        // constant spikes: narrow instance saturates, ISI settles to 1
        do_reset();
        for (int i = 0; i < 40; i++)
            cycle("t2", 1'b0, 1'b1, 1'b1, 1'b1);

        // consumer stalls over two window ends (3 then 5 spikes), then drains
        do_reset();
        for (int i = 0; i < 32; i++)
            cycle("t3", 1'b0, 1'b1, (i < 16) ? (i < 3) : (i < 21), 1'b0);
        for (int i = 0; i < 4; i++)
            cycle("t3_hold", 1'b0, 1'b0, 1'b0, 1'b0);
        check("t3_held_rate", int'(rate_a), 3);
        check("t3_overrun", int'(ovr_a), 1);
        cycle("t3_xfer", 1'b0, 1'b0, 1'b0, 1'b1);
        check("t3_drained", int'(val_a), 0);
        for (int i = 0; i < 4; i++)
            cycle("t3_sticky", 1'b0, 1'b1, 1'b0, 1'b1);

        // window end coincides with acceptance of the previous result
        do_reset();
        for (int i = 0; i < 32; i++)
            cycle("t4", 1'b0, 1'b1, (i % 3) == 0, i == 31);
        check("t4_valid", int'(val_a), 1);
        check("t4_ovr", int'(ovr_a), 0);

        // enable gap mid-window with spikes present during the gap
        do_reset();
        for (int i = 0; i < 6; i++)
            cycle("t5a", 1'b0, 1'b1, i == 2, 1'b1);
        for (int i = 0; i < 10; i++)
            cycle("t5_gap", 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++)
            cycle("t5b", 1'b0, 1'b1, i == 5, 1'b1);

        // reset at window cycle 9 after 3 spikes, then a silent window
        do_reset();
        for (int i = 0; i < 9; i++)
            cycle("t6a", 1'b0, 1'b1, i < 3, 1'b1);
        cycle("t6_rst", 1'b1, 1'b1, 1'b1, 1'b1);
        check("t6_rate_zero", int'(rate_a), 0);
        for (int i = 0; i < 18; i++)
            cycle("t6b", 1'b0, 1'b1, 1'b0, 1'b1);

        // randomized segments with varying spike density, enable and back-pressure
        for (int seg = 0; seg < 60; seg++) begin
            case ($urandom_range(0, 5))
                0: p_sp = 0;
                1: p_sp = 3;
                2: p_sp = 25;
                3: p_sp = 60;
                4: p_sp = 90;
                default: p_sp = 100;
            endcase
            case ($urandom_range(0, 2))
                0: p_en = 50;
                1: p_en = 90;
                default: p_en = 100;
            endcase
            case ($urandom_range(0, 3))
                0: p_rdy = 0;
                1: p_rdy = 20;
                2: p_rdy = 80;
                default: p_rdy = 100;
            endcase
            for (int i = 0; i < 50; i++)
                cycle("rand", $urandom_range(0, 399) == 0,
                      $urandom_range(0, 99) < p_en,
                      $urandom_range(0, 99) < p_sp,
                      $urandom_range(0, 99) < p_rdy);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
